// File: rtl/tamagotchi_btn_cond_if.sv
// Button bundle between the raw push-button pins and the conditioned outputs
// that feed tamagotchi_fsm. The master side drives the raw pins; the slave side is the conditioner.
interface tamagotchi_btn_cond_if;
    logic       btn_salud_in;
    logic       btn_energia_in;
    logic       btn_hambre_in;
    logic       btn_diversion_in;
    logic       btn_reset_in;
    logic       btn_test_in;
    logic       btn_salud;
    logic       btn_energia;
    logic       btn_hambre;
    logic       btn_diversion;
    logic       btn_reset;
    logic       btn_test;
    logic [2:0] count_reset;
    logic [2:0] count_test;

    modport master (
        output btn_salud_in, btn_energia_in, btn_hambre_in, btn_diversion_in,
        output btn_reset_in, btn_test_in,
        input  btn_salud, btn_energia, btn_hambre, btn_diversion,
        input  btn_reset, btn_test, count_reset, count_test
    );

    modport slave (
        input  btn_salud_in, btn_energia_in, btn_hambre_in, btn_diversion_in,
        input  btn_reset_in, btn_test_in,
        output btn_salud, btn_energia, btn_hambre, btn_diversion,
        output btn_reset, btn_test, count_reset, count_test
    );
endinterface

// File: rtl/tamagotchi_btn_cond.sv
// Synchronises and debounces six raw buttons: press pulses for the four action
// buttons, debounced levels plus saturating held-seconds counts for reset/test.
module tamagotchi_btn_cond #(
    parameter int DB_CYCLES  = 1_000_000,
    parameter int SEC_CYCLES = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tamagotchi_btn_cond_if.slave  bus
);
    localparam int DCW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int PW  = $clog2(SEC_CYCLES);
    localparam logic [DCW-1:0] DB_LAST  = DCW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  SEC_LAST = PW'(SEC_CYCLES - 1);

    // Channel order: 0 salud, 1 energia, 2 hambre, 3 diversion, 4 reset, 5 test
    logic [5:0]     raw;
    logic [5:0]     sync1_q, sync1_d;
    logic [5:0]     sync2_q, sync2_d;
    logic [5:0]     stable_q, stable_d;
    logic [DCW-1:0] dcnt_q [6];
    logic [DCW-1:0] dcnt_d [6];
    logic [3:0]     pulse_q, pulse_d;
    logic [PW-1:0]  pcnt_q [2];
    logic [PW-1:0]  pcnt_d [2];
    logic [2:0]     cnt_q  [2];
    logic [2:0]     cnt_d  [2];

    assign raw = {bus.btn_test_in, bus.btn_reset_in, bus.btn_diversion_in,
                  bus.btn_hambre_in, bus.btn_energia_in, bus.btn_salud_in};

    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        for (int i = 0; i < 6; i++) begin
            dcnt_d[i] = '0;
            // The DB_CYCLES-th consecutive mismatch flips the level; any match restarts.
            if (sync2_q[i] != stable_q[i]) begin
                if (dcnt_q[i] == DB_LAST) stable_d[i] = ~stable_q[i];
                else                      dcnt_d[i]   = dcnt_q[i] + DCW'(1);
            end
        end

        pulse_d = stable_d[3:0] & ~stable_q[3:0];

        for (int h = 0; h < 2; h++) begin
            pcnt_d[h] = '0;
            cnt_d[h]  = '0;
            // Clearing on stable_d lets the count drop on the same edge the level falls.
            if (stable_d[4+h]) begin
                pcnt_d[h] = pcnt_q[h];
                cnt_d[h]  = cnt_q[h];
                if (stable_q[4+h]) begin
                    if (pcnt_q[h] == SEC_LAST) begin
                        pcnt_d[h] = '0;
                        if (cnt_q[h] != 3'd7) cnt_d[h] = cnt_q[h] + 3'd1;
                    end else begin
                        pcnt_d[h] = pcnt_q[h] + PW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            dcnt_q   <= '{default: '0};
            pulse_q  <= '0;
            pcnt_q   <= '{default: '0};
            cnt_q    <= '{default: '0};
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            dcnt_q   <= dcnt_d;
            pulse_q  <= pulse_d;
            pcnt_q   <= pcnt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.btn_salud     = pulse_q[0];
    assign bus.btn_energia   = pulse_q[1];
    assign bus.btn_hambre    = pulse_q[2];
    assign bus.btn_diversion = pulse_q[3];
    assign bus.btn_reset     = stable_q[4];
    assign bus.btn_test      = stable_q[5];
    assign bus.count_reset   = cnt_q[0];
    assign bus.count_test    = cnt_q[1];
endmodule

// File: tb/tb_tamagotchi_btn_cond.sv
// Directed bench for tamagotchi_btn_cond with DB_CYCLES=4, SEC_CYCLES=10.
// Edge numbers in the loops count rising edges since the stimulus change.
module tb_tamagotchi_btn_cond;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    tamagotchi_btn_cond_if bus_if ();

    tamagotchi_btn_cond #(
        .DB_CYCLES  (4),
        .SEC_CYCLES (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [5:0] v);
        bus_if.btn_salud_in     = v[0];
        bus_if.btn_energia_in   = v[1];
        bus_if.btn_hambre_in    = v[2];
        bus_if.btn_diversion_in = v[3];
        bus_if.btn_reset_in     = v[4];
        bus_if.btn_test_in      = v[5];
    endtask

    function automatic int pulses();
        return int'({bus_if.btn_diversion, bus_if.btn_hambre, bus_if.btn_energia, bus_if.btn_salud});
    endfunction

    // Count of whole seconds for a level that rose at edge 6 (first increment at 16).
    function automatic int hold_exp(input int e);
        int c;
        if (e < 16) return 0;
        c = (e - 6) / 10;
        return (c > 7) ? 7 : c;
    endfunction

    // Run n edges; pulse vector must equal mask at edge 6 only, else zero.
    task automatic run_pulses(input string tag, input int n, input int mask);
        for (int e = 1; e <= n; e++) begin
            tick();
            check(tag, pulses(), (e == 6) ? mask : 0);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // 1: reset with all raws high, then release with salud held
        rst_n = 1'b0;
        set_raw(6'h3F);
        tick();
        tick();
        check("rst_pulses", pulses(), 0);
        check("rst_btn_reset", int'(bus_if.btn_reset), 0);
        check("rst_btn_test", int'(bus_if.btn_test), 0);
        check("rst_count_reset", int'(bus_if.count_reset), 0);
        check("rst_count_test", int'(bus_if.count_test), 0);
        rst_n = 1'b1;
        set_raw(6'h01);
        run_pulses("held_press", 10, 4'b0001);
        set_raw(6'h00);
        run_pulses("salud_release", 12, 0);

        // 2: glitch of 3 cycles rejected, 4 cycles accepted
        set_raw(6'h02);
        tick(); tick(); tick();
        set_raw(6'h00);
        run_pulses("glitch", 12, 0);
        set_raw(6'h02);
        tick(); tick(); tick(); tick();
        check("energia_pre", pulses(), 0);
        set_raw(6'h00);
        tick();
        check("energia_e5", pulses(), 0);
        tick();
        check("energia_e6", pulses(), 4'b0010);
        tick();
        check("energia_e7", pulses(), 0);
        run_pulses("energia_settle", 10, 0);

        // 3: bounce on press and on release
        for (int i = 0; i < 10; i++) begin
            set_raw((i % 2 == 0) ? 6'h04 : 6'h00);
            tick();
            check("bounce_press", pulses(), 0);
        end
        set_raw(6'h04);
        run_pulses("hambre_press", 12, 4'b0100);
        for (int i = 0; i < 10; i++) begin
            set_raw((i % 2 == 0) ? 6'h00 : 6'h04);
            tick();
            check("bounce_release", pulses(), 0);
        end
        set_raw(6'h00);
        run_pulses("hambre_release", 12, 0);

        // 4: hold count on reset channel, saturation, release
        set_raw(6'h10);
        for (int e = 1; e <= 100; e++) begin
            tick();
            check("hold_btn_reset", int'(bus_if.btn_reset), (e >= 6) ? 1 : 0);
            check("hold_count", int'(bus_if.count_reset), hold_exp(e));
        end
        set_raw(6'h00);
        for (int e = 1; e <= 8; e++) begin
            tick();
            check("rel_btn_reset", int'(bus_if.btn_reset), (e < 6) ? 1 : 0);
            check("rel_count", int'(bus_if.count_reset), (e < 6) ? 7 : 0);
        end

        // 5: simultaneous action presses, then parallel hold counts
        set_raw(6'h0F);
        run_pulses("four_pulses", 8, 4'b1111);
        set_raw(6'h00);
        run_pulses("four_release", 12, 0);
        set_raw(6'h30);
        for (int e = 1; e <= 36; e++) begin
            tick();
            check("par_counts", int'(bus_if.count_reset), int'(bus_if.count_test));
            check("par_btn_test", int'(bus_if.btn_test), (e >= 6) ? 1 : 0);
            check("par_count_test", int'(bus_if.count_test), hold_exp(e));
        end

        // 6: reset mid-hold with raws still held
        rst_n = 1'b0;
        tick();
        check("midrst_count_test", int'(bus_if.count_test), 0);
        check("midrst_btn_test", int'(bus_if.btn_test), 0);
        check("midrst_count_reset", int'(bus_if.count_reset), 0);
        rst_n = 1'b1;
        for (int e = 1; e <= 30; e++) begin
            tick();
            check("rerise_btn_test", int'(bus_if.btn_test), (e >= 6) ? 1 : 0);
            check("restart_count", int'(bus_if.count_test), hold_exp(e));
            check("rerise_pulses", pulses(), 0);
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
